k423_mem_arb: RTL and testbench

K423_MEM_ARB -- requirements
Module: k423_mem_arb

---
 rtl/k423_mem_arb.sv | 146 ++++++++++++++
 tb/tb_k423_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k423_mem_arb.sv
// rtl/k423_mem_arb.sv - two-port (fetch/load-store) round-robin memory arbiter with in-order response routing
module k423_mem_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OST_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // fetch port
    input  logic              if_req_vld_i,
    input  logic              if_req_wen_i,
    input  logic [ADDR_W-1:0] if_req_addr_i,
    input  logic [DATA_W-1:0] if_req_wdata_i,
    output logic              if_req_rdy_o,
    output logic              if_rsp_vld_o,
    output logic [DATA_W-1:0] if_rsp_rdata_o,
    // load/store port
    input  logic              ls_req_vld_i,
    input  logic              ls_req_wen_i,
    input  logic [ADDR_W-1:0] ls_req_addr_i,
    input  logic [DATA_W-1:0] ls_req_wdata_i,
    output logic              ls_req_rdy_o,
    output logic              ls_rsp_vld_o,
    output logic [DATA_W-1:0] ls_rsp_rdata_o,
    // shared memory port
    output logic              mem_req_vld_o,
    output logic              mem_req_wen_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_req_rdy_i,
    input  logic              mem_rsp_vld_i,
    input  logic [DATA_W-1:0] mem_rsp_rdata_i,
    // sticky: response arrived with nothing outstanding
    output logic              arb_err_o
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Requester IDs as stored in the outstanding FIFO
    localparam logic ID_IF = 1'b0;
    localparam logic ID_LS = 1'b1;

    logic                 last_q, last_d;
    logic                 lock_q, lock_d;
    logic                 lock_id_q, lock_id_d;
    logic [OST_DEPTH-1:0] id_mem_q, id_mem_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;

    logic gnt;
    logic gnt_vld;
    logic ost_full;
    logic ost_empty;
    logic push;
    logic pop;
    logic head_id;

    // Grant selection: a stalled requester keeps the grant; otherwise single requester wins, ties go to the one not last accepted
    always_comb begin
        gnt = ~last_q;
        if (lock_q && (lock_id_q ? ls_req_vld_i : if_req_vld_i)) begin
            gnt = lock_id_q;
        end else if (if_req_vld_i && !ls_req_vld_i) begin
            gnt = ID_IF;
        end else if (ls_req_vld_i && !if_req_vld_i) begin
            gnt = ID_LS;
        end
    end

    assign gnt_vld   = (gnt == ID_LS) ? ls_req_vld_i : if_req_vld_i;
    assign ost_full  = (count_q == CNT_W'(OST_DEPTH));
    assign ost_empty = (count_q == '0);

    assign mem_req_vld_o   = gnt_vld & ~ost_full;
    assign mem_req_wen_o   = (gnt == ID_LS) ? ls_req_wen_i   : if_req_wen_i;
    assign mem_req_addr_o  = (gnt == ID_LS) ? ls_req_addr_i  : if_req_addr_i;
    assign mem_req_wdata_o = (gnt == ID_LS) ? ls_req_wdata_i : if_req_wdata_i;

    assign if_req_rdy_o = (gnt == ID_IF) & mem_req_rdy_i & ~ost_full;
    assign ls_req_rdy_o = (gnt == ID_LS) & mem_req_rdy_i & ~ost_full;

    // A pop only happens when something is outstanding; a stray response is dropped
    assign push    = mem_req_vld_o & mem_req_rdy_i;
    assign pop     = mem_rsp_vld_i & ~ost_empty;
    assign head_id = id_mem_q[rd_ptr_q];

    assign if_rsp_vld_o   = pop & (head_id == ID_IF);
    assign ls_rsp_vld_o   = pop & (head_id == ID_LS);
    assign if_rsp_rdata_o = mem_rsp_rdata_i;
    assign ls_rsp_rdata_o = mem_rsp_rdata_i;

    assign arb_err_o = err_q;

    // Next-state for round-robin pointer, grant lock, ID FIFO and error flag
    always_comb begin
        last_d    = last_q;
        lock_d    = gnt_vld & ~push;
        lock_id_d = gnt;
        id_mem_d  = id_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | (mem_rsp_vld_i & ost_empty);

        if (push) begin
            last_d             = gnt;
            id_mem_d[wr_ptr_q] = gnt;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards anything outstanding
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q    <= ID_IF;
            lock_q    <= 1'b0;
            lock_id_q <= ID_IF;
            id_mem_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            id_mem_q  <= id_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_k423_mem_arb.sv
// tb/tb_k423_mem_arb.sv - scoreboard bench for k423_mem_arb
module tb_k423_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_vld = 1'b0, if_req_wen = 1'b0;
    logic [31:0] if_req_addr = '0, if_req_wdata = '0;
    logic        if_req_rdy, if_rsp_vld;
    logic [31:0] if_rsp_rdata;
    logic        ls_req_vld = 1'b0, ls_req_wen = 1'b0;
    logic [31:0] ls_req_addr = '0, ls_req_wdata = '0;
    logic        ls_req_rdy, ls_rsp_vld;
    logic [31:0] ls_rsp_rdata;
    logic        mem_req_vld, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_rdy = 1'b0, mem_rsp_vld = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        arb_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        id;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          cyc;
        logic        id;
        logic [31:0] data;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    k423_mem_arb dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .if_req_vld_i   (if_req_vld),
        .if_req_wen_i   (if_req_wen),
        .if_req_addr_i  (if_req_addr),
        .if_req_wdata_i (if_req_wdata),
        .if_req_rdy_o   (if_req_rdy),
        .if_rsp_vld_o   (if_rsp_vld),
        .if_rsp_rdata_o (if_rsp_rdata),
        .ls_req_vld_i   (ls_req_vld),
        .ls_req_wen_i   (ls_req_wen),
        .ls_req_addr_i  (ls_req_addr),
        .ls_req_wdata_i (ls_req_wdata),
        .ls_req_rdy_o   (ls_req_rdy),
        .ls_rsp_vld_o   (ls_rsp_vld),
        .ls_rsp_rdata_o (ls_rsp_rdata),
        .mem_req_vld_o  (mem_req_vld),
        .mem_req_wen_o  (mem_req_wen),
        .mem_req_addr_o (mem_req_addr),
        .mem_req_wdata_o(mem_req_wdata),
        .mem_req_rdy_i  (mem_req_rdy),
        .mem_rsp_vld_i  (mem_rsp_vld),
        .mem_rsp_rdata_i(mem_rsp_rdata),
        .arb_err_o      (arb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_if(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        if_req_vld = v; if_req_wen = w; if_req_addr = a; if_req_wdata = d;
    endtask

    task automatic set_ls(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        ls_req_vld = v; ls_req_wen = w; ls_req_addr = a; ls_req_wdata = d;
    endtask

    task automatic set_mem(input logic rdy, input logic rv, input logic [31:0] rd);
        mem_req_rdy = rdy; mem_rsp_vld = rv; mem_rsp_rdata = rd;
    endtask

    task automatic exp_acc(input logic id, input logic w, input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.cyc = cyc; e.id = id; e.wen = w; e.addr = a; e.wdata = d;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic id, input logic [31:0] d);
        rsp_t e;
        e.cyc = cyc; e.id = id; e.data = d;
        rsp_q.push_back(e);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every memory acceptance and every routed response is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_vld && mem_req_rdy) begin
                if (acc_q.size() == 0) begin
                    chk("acc_unexpected", {32'h0, mem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("acc_cycle", 64'(cyc), 64'(e.cyc));
                    chk("acc_rdy_id", {62'h0, if_req_rdy, ls_req_rdy}, e.id ? 64'h1 : 64'h2);
                    chk("acc_wen", {63'h0, mem_req_wen}, {63'h0, e.wen});
                    chk("acc_addr", {32'h0, mem_req_addr}, {32'h0, e.addr});
                    chk("acc_wdata", {32'h0, mem_req_wdata}, {32'h0, e.wdata});
                end
            end
            if (if_rsp_vld && ls_rsp_vld) begin
                chk("rsp_both_valid", 64'h3, 64'h0);
            end else if (if_rsp_vld || ls_rsp_vld) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {62'h0, if_rsp_vld, ls_rsp_vld}, 64'h0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_id", {62'h0, if_rsp_vld, ls_rsp_vld}, e.id ? 64'h1 : 64'h2);
                    chk("rsp_data", {32'h0, ls_rsp_vld ? ls_rsp_rdata : if_rsp_rdata}, {32'h0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        #2;
        set_if(1'b0, 1'b0, 32'h0, 32'h0);
        set_ls(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0);
        to_neg();
        chk("rst_mem_vld", {63'h0, mem_req_vld}, 64'h0);
        chk("rst_if_rsp", {63'h0, if_rsp_vld}, 64'h0);
        chk("rst_ls_rsp", {63'h0, ls_rsp_vld}, 64'h0);
        chk("rst_err", {63'h0, arb_err}, 64'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Both requesting from reset: LS first, then alternate; responses drain in order
        set_if(1'b1, 1'b0, 32'h10, 32'h0);
        set_ls(1'b1, 1'b1, 32'h20, 32'h55);
        set_mem(1'b1, 1'b0, 32'h0);
        exp_acc(1'b1, 1'b1, 32'h20, 32'h55);
        next_cyc();
        set_mem(1'b1, 1'b1, 32'h11);
        exp_acc(1'b0, 1'b0, 32'h10, 32'h0);
        exp_rsp(1'b1, 32'h11);
        next_cyc();
        set_mem(1'b1, 1'b1, 32'h22);
        exp_acc(1'b1, 1'b1, 32'h20, 32'h55);
        exp_rsp(1'b0, 32'h22);
        next_cyc();
        set_mem(1'b1, 1'b1, 32'h33);
        exp_acc(1'b0, 1'b0, 32'h10, 32'h0);
        exp_rsp(1'b1, 32'h33);
        next_cyc();
        set_if(1'b0, 1'b0, 32'h0, 32'h0);
        set_ls(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b1, 1'b1, 32'h44);
        exp_rsp(1'b0, 32'h44);
        next_cyc();
        set_mem(1'b0, 1'b0, 32'h0);
        next_cyc();

        // Grant lock: IF stalled for three cycles keeps the grant even after LS arrives
        set_if(1'b1, 1'b0, 32'h30, 32'h0);
        to_neg();
        chk("lock_c0_addr", {32'h0, mem_req_addr}, 64'h30);
        chk("lock_c0_if_rdy", {63'h0, if_req_rdy}, 64'h0);
        next_cyc();
        set_ls(1'b1, 1'b0, 32'h40, 32'h0);
        to_neg();
        chk("lock_c1_addr", {32'h0, mem_req_addr}, 64'h30);
        chk("lock_c1_ls_rdy", {63'h0, ls_req_rdy}, 64'h0);
        next_cyc();
        to_neg();
        chk("lock_c2_addr", {32'h0, mem_req_addr}, 64'h30);
        next_cyc();
        set_mem(1'b1, 1'b0, 32'h0);
        exp_acc(1'b0, 1'b0, 32'h30, 32'h0);
        next_cyc();
        exp_acc(1'b1, 1'b0, 32'h40, 32'h0);
        next_cyc();

        // FIFO full: nothing accepted, including in the cycle a response pops
        to_neg();
        chk("full_mem_vld", {63'h0, mem_req_vld}, 64'h0);
        chk("full_rdy", {62'h0, if_req_rdy, ls_req_rdy}, 64'h0);
        next_cyc();
        set_mem(1'b1, 1'b1, 32'hA0);
        exp_rsp(1'b0, 32'hA0);
        to_neg();
        chk("full_pop_mem_vld", {63'h0, mem_req_vld}, 64'h0);
        next_cyc();
        set_mem(1'b1, 1'b0, 32'h0);
        exp_acc(1'b0, 1'b0, 32'h30, 32'h0);
        next_cyc();
        set_if(1'b0, 1'b0, 32'h0, 32'h0);
        set_ls(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b1, 1'b1, 32'hB1);
        exp_rsp(1'b1, 32'hB1);
        next_cyc();
        set_mem(1'b1, 1'b1, 32'hB2);
        exp_rsp(1'b0, 32'hB2);
        next_cyc();
        set_mem(1'b0, 1'b0, 32'h0);
        next_cyc();

        // In-order routing: IF 0x100 then LS 0x200, responses 0xA then 0xB
        set_mem(1'b1, 1'b0, 32'h0);
        set_if(1'b1, 1'b1, 32'h100, 32'hDEAD);
        exp_acc(1'b0, 1'b1, 32'h100, 32'hDEAD);
        next_cyc();
        set_if(1'b0, 1'b0, 32'h0, 32'h0);
        set_ls(1'b1, 1'b0, 32'h200, 32'h0);
        exp_acc(1'b1, 1'b0, 32'h200, 32'h0);
        next_cyc();
        set_ls(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b1, 32'hA);
        exp_rsp(1'b0, 32'hA);
        next_cyc();
        set_mem(1'b0, 1'b1, 32'hB);
        exp_rsp(1'b1, 32'hB);
        next_cyc();
        set_mem(1'b0, 1'b0, 32'h0);
        next_cyc();

        // Reset with one request outstanding; the later response must be treated as stray
        set_mem(1'b1, 1'b0, 32'h0);
        set_if(1'b1, 1'b0, 32'h300, 32'h0);
        exp_acc(1'b0, 1'b0, 32'h300, 32'h0);
        next_cyc();
        set_if(1'b0, 1'b0, 32'h0, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_err", {63'h0, arb_err}, 64'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        set_mem(1'b0, 1'b1, 32'hEE);
        to_neg();
        chk("stray_no_rsp", {62'h0, if_rsp_vld, ls_rsp_vld}, 64'h0);
        chk("stray_err_before_edge", {63'h0, arb_err}, 64'h0);
        next_cyc();
        set_mem(1'b0, 1'b0, 32'h0);
        to_neg();
        chk("stray_err_set", {63'h0, arb_err}, 64'h1);
        next_cyc();
        next_cyc();
        to_neg();
        chk("stray_err_held", {63'h0, arb_err}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("err_async_clear", {63'h0, arb_err}, 64'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        next_cyc();

        chk("acc_queue_empty", 64'(acc_q.size()), 64'h0);
        chk("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
